// File: rtl/garage_door_sequencer.sv
// garage_door_sequencer
//
// Supervisory sequencer for the garage door motor pair. Wall and remote
// buttons are merged into a single rising-edge command that opens, stops,
// closes or restarts the door. Every motor start goes through a motor-off
// dead time. A beam break while closing reverses the door. The door closes
// automatically after a hold time in OPEN. A travel timeout or an
// impossible limit-switch combination latches FAULT until it is cleared.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   Btn_Wall     wall button level (already synchronised)
//   Btn_Remote   remote button level (already synchronised)
//   UP_Max       door fully open limit switch
//   DN_Max       door fully closed limit switch
//   Obstruct     beam-break sensor, 1 = blocked
//   Clear_Fault  leaves FAULT when 1
//   UP_M         raise motor drive
//   DN_M         lower motor drive
//   Fault        1 while in FAULT
//   State        current state code
//
// state    | code | meaning
// ---------+------+-------------------------------------------------
// CLOSED   |  0   | door resting on the closed limit
// OPENING  |  1   | raise motor on
// OPEN     |  2   | door resting on the open limit, auto-close timing
// CLOSING  |  3   | lower motor on
// STOPPED  |  4   | halted part-way, or waiting to resolve limits
// DEAD     |  5   | motors off before a start, direction in pend_dir
// FAULT    |  6   | motors off until Clear_Fault

module garage_door_sequencer #(
    parameter int DEAD_CYCLES = 4,
    parameter int TRAVEL_MAX  = 1000,
    parameter int AUTO_CLOSE  = 5000,
    parameter int CNT_W       = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Btn_Wall,
    input  logic       Btn_Remote,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       Obstruct,
    input  logic       Clear_Fault,
    output logic       UP_M,
    output logic       DN_M,
    output logic       Fault,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_STOPPED = 3'd4,
        ST_DEAD    = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    localparam logic DIR_DN = 1'b0;
    localparam logic DIR_UP = 1'b1;

    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
    // When auto-close is disabled the compare value is never used.
    localparam logic [CNT_W-1:0] AUTO_LAST   =
        (AUTO_CLOSE == 0) ? '0 : CNT_W'(AUTO_CLOSE - 1);
    localparam logic             AUTO_EN     = (AUTO_CLOSE != 0);

    state_t           state;
    state_t           state_nxt;
    logic             last_dir;
    logic             last_dir_nxt;
    logic             pend_dir;
    logic             pend_dir_nxt;
    logic             btn_q;
    logic             btn_q_d;
    logic             cmd;
    logic [CNT_W-1:0] timer;

    // Merged button level, so overlapping presses form one edge and a held
    // button cannot repeat.
    assign cmd = btn_q & ~btn_q_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_STOPPED;
            last_dir <= DIR_DN;
            pend_dir <= DIR_UP;
            btn_q    <= 1'b0;
            btn_q_d  <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_dir <= last_dir_nxt;
            pend_dir <= pend_dir_nxt;
            btn_q    <= Btn_Wall | Btn_Remote;
            btn_q_d  <= btn_q;
        end
    end

    // Time in the current state. A blocked beam in OPEN keeps restarting the
    // auto-close hold, so the door never starts closing onto an obstacle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if ((state == ST_OPEN) && Obstruct) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        last_dir_nxt = last_dir;
        pend_dir_nxt = pend_dir;

        if ((state != ST_FAULT) && UP_Max && DN_Max) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state)
                ST_STOPPED: begin
                    if (DN_Max) begin
                        state_nxt = ST_CLOSED;
                    end else if (UP_Max) begin
                        state_nxt = ST_OPEN;
                    end else if (cmd) begin
                        state_nxt    = ST_DEAD;
                        pend_dir_nxt = ~last_dir;
                    end
                end
                ST_CLOSED: begin
                    if (!DN_Max) begin
                        state_nxt = ST_STOPPED;
                    end else if (cmd) begin
                        state_nxt    = ST_DEAD;
                        pend_dir_nxt = DIR_UP;
                    end
                end
                ST_DEAD: begin
                    if (timer == DEAD_LAST) begin
                        if (pend_dir == DIR_UP) begin
                            state_nxt = ST_OPENING;
                        end else if (Obstruct) begin
                            // Refuse to start closing into a blocked beam.
                            state_nxt    = ST_STOPPED;
                            last_dir_nxt = DIR_DN;
                        end else begin
                            state_nxt = ST_CLOSING;
                        end
                    end
                end
                ST_OPENING: begin
                    if (UP_Max) begin
                        state_nxt = ST_OPEN;
                    end else if (timer == TRAVEL_LAST) begin
                        state_nxt = ST_FAULT;
                    end else if (cmd) begin
                        state_nxt    = ST_STOPPED;
                        last_dir_nxt = DIR_UP;
                    end
                end
                ST_OPEN: begin
                    if (!UP_Max) begin
                        state_nxt    = ST_STOPPED;
                        last_dir_nxt = DIR_UP;
                    end else if (AUTO_EN && (timer == AUTO_LAST) && !Obstruct) begin
                        state_nxt    = ST_DEAD;
                        pend_dir_nxt = DIR_DN;
                    end else if (cmd) begin
                        state_nxt    = ST_DEAD;
                        pend_dir_nxt = DIR_DN;
                    end
                end
                ST_CLOSING: begin
                    if (DN_Max) begin
                        state_nxt = ST_CLOSED;
                    end else if (Obstruct) begin
                        state_nxt    = ST_DEAD;
                        pend_dir_nxt = DIR_UP;
                    end else if (timer == TRAVEL_LAST) begin
                        state_nxt = ST_FAULT;
                    end else if (cmd) begin
                        state_nxt    = ST_STOPPED;
                        last_dir_nxt = DIR_DN;
                    end
                end
                ST_FAULT: begin
                    if (Clear_Fault) begin
                        state_nxt    = ST_STOPPED;
                        last_dir_nxt = DIR_DN;
                    end
                end
                default: begin
                    state_nxt = ST_STOPPED;
                end
            endcase
        end
    end

    // Outputs decode the state register only, so the two motors are mutually
    // exclusive by construction and reset drops them without a clock.
    assign UP_M  = (state == ST_OPENING);
    assign DN_M  = (state == ST_CLOSING);
    assign Fault = (state == ST_FAULT);
    assign State = state;

endmodule

// File: tb/tb_garage_door_sequencer.sv
// tb_garage_door_sequencer
//
// Directed scenarios for garage_door_sequencer with DEAD_CYCLES = 2,
// TRAVEL_MAX = 20 and AUTO_CLOSE = 10. Each clocked step pushes the expected
// state into a scoreboard queue; after the edge the entry is popped and
// State, UP_M, DN_M and Fault are compared against it.

module tb_garage_door_sequencer;

    logic       CLK;
    logic       RST;
    logic       Btn_Wall;
    logic       Btn_Remote;
    logic       UP_Max;
    logic       DN_Max;
    logic       Obstruct;
    logic       Clear_Fault;
    logic       UP_M;
    logic       DN_M;
    logic       Fault;
    logic [2:0] State;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
    } exp_t;

    exp_t sb[$];

    garage_door_sequencer #(
        .DEAD_CYCLES(2),
        .TRAVEL_MAX (20),
        .AUTO_CLOSE (10),
        .CNT_W      (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Btn_Wall   (Btn_Wall),
        .Btn_Remote (Btn_Remote),
        .UP_Max     (UP_Max),
        .DN_Max     (DN_Max),
        .Obstruct   (Obstruct),
        .Clear_Fault(Clear_Fault),
        .UP_M       (UP_M),
        .DN_M       (DN_M),
        .Fault      (Fault),
        .State      (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check all outputs against an expected state code; the motor and fault
    // outputs follow directly from the state.
    task automatic check_outputs(input string tag, input logic [2:0] st);
        check_val({tag, "_state"}, {5'd0, State}, {5'd0, st});
        check_val({tag, "_up_m"},  {7'd0, UP_M},  {7'd0, (st == 3'd1)});
        check_val({tag, "_dn_m"},  {7'd0, DN_M},  {7'd0, (st == 3'd3)});
        check_val({tag, "_fault"}, {7'd0, Fault}, {7'd0, (st == 3'd6)});
    endtask

    task automatic tick(input string tag, input logic [2:0] st);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            check_outputs(e.tag, e.st);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST         = 1'b0;
        Btn_Wall    = 1'b0;
        Btn_Remote  = 1'b0;
        UP_Max      = 1'b0;
        DN_Max      = 1'b1;
        Obstruct    = 1'b0;
        Clear_Fault = 1'b0;

        // Reset state, then limits resolve on the first edge.
        #12;
        check_outputs("in_reset", 3'd4);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_outputs("rst_released", 3'd4);
        tick("rst_rel_closed", 3'd0);

        // Remote pulse from CLOSED, open with 5 cycles of UP_M.
        Btn_Remote = 1'b1;
        tick("remote_edge", 3'd0);
        Btn_Remote = 1'b0;
        tick("remote_dead0", 3'd5);
        tick("remote_dead1", 3'd5);
        tick("remote_opening", 3'd1);
        DN_Max = 1'b0;
        repeat (4) tick("open_travel", 3'd1);
        UP_Max = 1'b1;
        tick("reach_open", 3'd2);

        // Auto-close after 10 cycles, then reverse on obstruction.
        repeat (9) tick("open_hold", 3'd2);
        tick("auto_dead0", 3'd5);
        tick("auto_dead1", 3'd5);
        tick("auto_closing", 3'd3);
        UP_Max = 1'b0;
        tick("closing", 3'd3);
        Obstruct = 1'b1;
        tick("obst_rev0", 3'd5);
        Obstruct = 1'b0;
        tick("obst_rev1", 3'd5);
        tick("obst_opening", 3'd1);

        // Travel timeout on the 20th edge, presses ignored in FAULT.
        repeat (19) tick("timeout_run", 3'd1);
        tick("timeout_fault", 3'd6);
        Btn_Wall = 1'b1;
        tick("fault_press", 3'd6);
        Btn_Wall = 1'b0;
        repeat (2) tick("fault_hold", 3'd6);
        Clear_Fault = 1'b1;
        tick("fault_clear", 3'd4);
        Clear_Fault = 1'b0;
        DN_Max = 1'b1;
        tick("to_closed", 3'd0);

        // Overlapping presses form one command; stop mid-opening; restart down.
        Btn_Wall   = 1'b1;
        Btn_Remote = 1'b1;
        tick("dual_edge", 3'd0);
        Btn_Wall = 1'b0;
        tick("dual_dead0", 3'd5);
        tick("dual_dead1", 3'd5);
        Btn_Remote = 1'b0;
        tick("dual_opening", 3'd1);
        DN_Max = 1'b0;
        repeat (2) tick("dual_no_repeat", 3'd1);
        Btn_Wall = 1'b1;
        tick("mid_press", 3'd1);
        Btn_Wall = 1'b0;
        tick("mid_stop", 3'd4);
        Btn_Remote = 1'b1;
        tick("restart_edge", 3'd4);
        Btn_Remote = 1'b0;
        tick("restart_dead0", 3'd5);
        tick("restart_dead1", 3'd5);
        tick("restart_closing", 3'd3);

        // Limit conflict in OPEN.
        DN_Max = 1'b1;
        tick("close_done", 3'd0);
        Btn_Wall = 1'b1;
        tick("s6_edge", 3'd0);
        Btn_Wall = 1'b0;
        tick("s6_dead0", 3'd5);
        tick("s6_dead1", 3'd5);
        tick("s6_opening", 3'd1);
        DN_Max = 1'b0;
        UP_Max = 1'b1;
        tick("s6_open", 3'd2);
        DN_Max = 1'b1;
        tick("conflict", 3'd6);
        DN_Max      = 1'b0;
        Clear_Fault = 1'b1;
        tick("conflict_clear", 3'd4);
        Clear_Fault = 1'b0;
        tick("s6_reopen", 3'd2);
        Btn_Wall = 1'b1;
        tick("s6_press", 3'd2);
        Btn_Wall = 1'b0;
        tick("s6_dead0b", 3'd5);
        tick("s6_dead1b", 3'd5);
        tick("s6_closing", 3'd3);
        UP_Max = 1'b0;
        tick("s6_closing2", 3'd3);

        // Asynchronous reset mid-closing drops the motor without an edge.
        #2;
        RST = 1'b0;
        #1;
        check_outputs("async_rst", 3'd4);
        UP_Max = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        tick("post_rst_open", 3'd2);

        // Blocked beam holds the auto-close timer and aborts a close start.
        Obstruct = 1'b1;
        repeat (12) tick("obst_hold", 3'd2);
        Btn_Wall = 1'b1;
        tick("obst_press", 3'd2);
        Btn_Wall = 1'b0;
        tick("obst_dead0", 3'd5);
        tick("obst_dead1", 3'd5);
        tick("obst_abort", 3'd4);
        Obstruct = 1'b0;
        tick("final_open", 3'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
